hcp_tx_arbiter: RTL and testbench

Frame-level arbiter that shares the single HCP transmit path (9-bit framed byte stream feeding the HCP output/PTP-correction stage) among three buffered frame sources: PTP, NMAC report and ARP request. Grants whole frames, reads each one from its source FIFO by descriptor length, repairs framing markers, and enforces a fixed idle gap so the downstream stage can drain its 8-byte delay line and insert preamble/SFD before the next frame starts.

---
 rtl/hcp_tx_arbiter_pkg.sv | 10 +
 rtl/hcp_tx_arbiter_if.sv | 29 ++
 rtl/hcp_tx_arbiter_rr_sel.sv | 16 +
 rtl/hcp_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_hcp_tx_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/hcp_tx_arbiter_pkg.sv
// hcp_tx_arb_pkg: shared state encoding, source indices and default timing/length limits
package hcp_tx_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_FLUSH, ST_GAP} state_t;
  localparam int SRC_PTP = 0;
  localparam int SRC_NMAC = 1;
  localparam int SRC_ARP = 2;
  localparam int GAP_DEF = 20;
  localparam int MIN_DEF = 60;
  localparam int MAX_DEF = 1518;
endpackage

// File: rtl/hcp_tx_arbiter_if.sv
// hcp_tx_arbiter_if: source descriptor/FIFO handshakes and the framed byte stream to the HCP output stage
interface hcp_tx_arbiter_if;
  logic i_ptp_frame_ready, i_nmac_frame_ready, i_arp_frame_ready;
  logic [10:0] iv_ptp_len, iv_nmac_len, iv_arp_len;
  logic o_ptp_desc_ack, o_nmac_desc_ack, o_arp_desc_ack;
  logic o_ptp_rd, o_nmac_rd, o_arp_rd;
  logic [8:0] iv_ptp_data, iv_nmac_data, iv_arp_data;
  logic [8:0] ov_data;
  logic o_data_wr, o_fmt_err, o_len_err;
  logic [15:0] ov_ptp_frame_cnt, ov_nmac_frame_cnt, ov_arp_frame_cnt;
  modport master (
    input i_ptp_frame_ready, i_nmac_frame_ready, i_arp_frame_ready,
    input iv_ptp_len, iv_nmac_len, iv_arp_len,
    input iv_ptp_data, iv_nmac_data, iv_arp_data,
    output o_ptp_desc_ack, o_nmac_desc_ack, o_arp_desc_ack,
    output o_ptp_rd, o_nmac_rd, o_arp_rd,
    output ov_data, o_data_wr, o_fmt_err, o_len_err,
    output ov_ptp_frame_cnt, ov_nmac_frame_cnt, ov_arp_frame_cnt
  );
  modport slave (
    output i_ptp_frame_ready, i_nmac_frame_ready, i_arp_frame_ready,
    output iv_ptp_len, iv_nmac_len, iv_arp_len,
    output iv_ptp_data, iv_nmac_data, iv_arp_data,
    input o_ptp_desc_ack, o_nmac_desc_ack, o_arp_desc_ack,
    input o_ptp_rd, o_nmac_rd, o_arp_rd,
    input ov_data, o_data_wr, o_fmt_err, o_len_err,
    input ov_ptp_frame_cnt, ov_nmac_frame_cnt, ov_arp_frame_cnt
  );
endinterface

// File: rtl/hcp_tx_arbiter_rr_sel.sv
// hcp_tx_rr_sel: ptp strict priority, nmac/arp round-robin (ptr=1 favours arp)
module hcp_tx_rr_sel
  import hcp_tx_arb_pkg::*;
(
  input  logic [2:0] rdy,
  input  logic       ptr,
  output logic       vld,
  output logic [1:0] idx
);
  // Pick the winning source index from the ready bits and the round-robin pointer
  always_comb begin
    vld = |rdy;
    idx = rdy[SRC_PTP] ? 2'(SRC_PTP) :
          (rdy[SRC_NMAC] && (!rdy[SRC_ARP] || !ptr)) ? 2'(SRC_NMAC) : 2'(SRC_ARP);
  end
endmodule

// File: rtl/hcp_tx_arbiter.sv
// hcp_tx_arbiter: frame-level arbiter sharing the HCP transmit path among ptp, nmac and arp sources
module hcp_tx_arbiter
  import hcp_tx_arb_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_DEF,
  parameter int MIN_LEN = MIN_DEF,
  parameter int MAX_LEN = MAX_DEF
) (
  input logic i_clk,
  input logic i_rst_n,
  hcp_tx_arbiter_if.master bus
);
  state_t state_q, state_d;
  logic [1:0] src_q, src_d, gidx;
  logic [10:0] len_q, len_d, rcnt_q, rcnt_d, wcnt_q, wcnt_d, wnum, glen;
  logic [15:0] gcnt_q, gcnt_d;
  logic bad_q, bad_d, ptr_q, ptr_d, rd1_q, rd1_d, mis_q, mis_d;
  logic gvld, gbad, mark, last, cur_mis;
  logic [2:0] rdy, ack_q, ack_d, rd_q, rd_d;
  logic wr_q, wr_d, fmt_q, fmt_d, lerr_q, lerr_d;
  logic [8:0] dout_q, dout_d, din;
  logic [10:0] len_a [3];
  logic [8:0] dat_a [3];
  logic [15:0] cnt_q [3], cnt_d [3];
  assign rdy = {bus.i_arp_frame_ready, bus.i_nmac_frame_ready, bus.i_ptp_frame_ready};
  assign len_a[SRC_PTP] = bus.iv_ptp_len;
  assign len_a[SRC_NMAC] = bus.iv_nmac_len;
  assign len_a[SRC_ARP] = bus.iv_arp_len;
  assign dat_a[SRC_PTP] = bus.iv_ptp_data;
  assign dat_a[SRC_NMAC] = bus.iv_nmac_data;
  assign dat_a[SRC_ARP] = bus.iv_arp_data;
  assign glen = len_a[gidx];
  assign gbad = (glen < 11'(MIN_LEN)) || (glen > 11'(MAX_LEN));
  assign din = dat_a[src_q];
  assign wnum = wcnt_q + 11'd1;
  assign last = wnum == len_q;
  assign mark = (wnum == 11'd1) || last;
  assign cur_mis = mis_q || (rd1_q && (din[8] != mark));
  hcp_tx_rr_sel u_sel (.rdy(rdy), .ptr(ptr_q), .vld(gvld), .idx(gidx));
  // Frame control: grant in IDLE, pace len reads, one flush cycle, then the idle gap (which overlaps the next grant)
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    len_d = len_q;
    bad_d = bad_q;
    ptr_d = ptr_q;
    rcnt_d = rcnt_q;
    gcnt_d = gcnt_q;
    ack_d = '0;
    rd_d = '0;
    lerr_d = 1'b0;
    case (state_q)
      ST_IDLE: if (gvld) begin
        src_d = gidx;
        len_d = glen;
        bad_d = gbad;
        ack_d[gidx] = 1'b1;
        lerr_d = gbad && (glen != 11'd0);
        ptr_d = (gidx == 2'(SRC_PTP)) ? ptr_q : (gidx == 2'(SRC_NMAC));
        rd_d[gidx] = glen != 11'd0;
        rcnt_d = glen - 11'd1;
        state_d = (glen == 11'd0) ? ST_IDLE : ST_READ;
      end
      ST_READ: begin
        rd_d[src_q] = rcnt_q != 11'd0;
        rcnt_d = rcnt_q - 11'd1;
        state_d = (rcnt_q == 11'd0) ? ST_FLUSH : ST_READ;
      end
      ST_FLUSH: begin
        gcnt_d = 16'(GAP_CYCLES - 3);
        state_d = bad_q ? ST_IDLE : ST_GAP;
      end
      default: begin
        gcnt_d = gcnt_q - 16'd1;
        state_d = (gcnt_q == 16'd0) ? ST_IDLE : ST_GAP;
      end
    endcase
  end
  // Data path: marker repair on the returning word, discard of illegal lengths, error pulse and frame counters
  always_comb begin
    rd1_d = |rd_q;
    wcnt_d = (state_q == ST_IDLE) ? 11'd0 : wcnt_q + {10'd0, rd1_q};
    mis_d = (state_q == ST_IDLE) ? 1'b0 : cur_mis;
    wr_d = rd1_q && !bad_q;
    dout_d = wr_d ? {mark, din[7:0]} : 9'd0;
    fmt_d = wr_d && last && cur_mis;
    cnt_d = cnt_q;
    if (wr_d && last) cnt_d[src_q] = cnt_q[src_q] + 16'd1;
  end
  // State and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      src_q <= '0;
      len_q <= '0;
      bad_q <= 1'b0;
      ptr_q <= 1'b0;
      rcnt_q <= '0;
      gcnt_q <= '0;
      ack_q <= '0;
      rd_q <= '0;
      lerr_q <= 1'b0;
      rd1_q <= 1'b0;
      wcnt_q <= '0;
      mis_q <= 1'b0;
      wr_q <= 1'b0;
      dout_q <= '0;
      fmt_q <= 1'b0;
      cnt_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      len_q <= len_d;
      bad_q <= bad_d;
      ptr_q <= ptr_d;
      rcnt_q <= rcnt_d;
      gcnt_q <= gcnt_d;
      ack_q <= ack_d;
      rd_q <= rd_d;
      lerr_q <= lerr_d;
      rd1_q <= rd1_d;
      wcnt_q <= wcnt_d;
      mis_q <= mis_d;
      wr_q <= wr_d;
      dout_q <= dout_d;
      fmt_q <= fmt_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.o_ptp_desc_ack = ack_q[SRC_PTP];
  assign bus.o_nmac_desc_ack = ack_q[SRC_NMAC];
  assign bus.o_arp_desc_ack = ack_q[SRC_ARP];
  assign bus.o_ptp_rd = rd_q[SRC_PTP];
  assign bus.o_nmac_rd = rd_q[SRC_NMAC];
  assign bus.o_arp_rd = rd_q[SRC_ARP];
  assign bus.ov_data = dout_q;
  assign bus.o_data_wr = wr_q;
  assign bus.o_fmt_err = fmt_q;
  assign bus.o_len_err = lerr_q;
  assign bus.ov_ptp_frame_cnt = cnt_q[SRC_PTP];
  assign bus.ov_nmac_frame_cnt = cnt_q[SRC_NMAC];
  assign bus.ov_arp_frame_cnt = cnt_q[SRC_ARP];
endmodule

// File: tb/tb_hcp_tx_arbiter.sv
// tb_hcp_tx_arbiter: source FIFO models plus a word scoreboard for the frame arbiter
module tb_hcp_tx_arbiter;
  import hcp_tx_arb_pkg::*;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  hcp_tx_arbiter_if bus();
  hcp_tx_arbiter #(.GAP_CYCLES(20), .MIN_LEN(60), .MAX_LEN(1518)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus)
  );
  always #5 i_clk = ~i_clk;
  logic [2:0] t_rdy = '0;
  logic [10:0] t_len [3];
  logic [8:0] t_dat [3];
  logic [2:0] t_rd, t_ack;
  logic [15:0] t_cnt [3];
  assign bus.i_ptp_frame_ready = t_rdy[0];
  assign bus.i_nmac_frame_ready = t_rdy[1];
  assign bus.i_arp_frame_ready = t_rdy[2];
  assign bus.iv_ptp_len = t_len[0];
  assign bus.iv_nmac_len = t_len[1];
  assign bus.iv_arp_len = t_len[2];
  assign bus.iv_ptp_data = t_dat[0];
  assign bus.iv_nmac_data = t_dat[1];
  assign bus.iv_arp_data = t_dat[2];
  assign t_rd = {bus.o_arp_rd, bus.o_nmac_rd, bus.o_ptp_rd};
  assign t_ack = {bus.o_arp_desc_ack, bus.o_nmac_desc_ack, bus.o_ptp_desc_ack};
  assign t_cnt[0] = bus.ov_ptp_frame_cnt;
  assign t_cnt[1] = bus.ov_nmac_frame_cnt;
  assign t_cnt[2] = bus.ov_arp_frame_cnt;
  int errs = 0, checks = 0;
  int dlen [3][$];
  bit dcor [3][$];
  int cur_len [3], wp [3], seq [3], rd_tot [3], len_tot [3], cnt_exp [3];
  bit cur_cor [3], rd_prev [3];
  // scoreboard entry: [13]=first [12]=corrupt src [11]=last [10:9]=src [8:0]=expected output word
  logic [13:0] expq [$];
  logic [13:0] e;
  int ackcyc [$], gnt_log [$], eo [$];
  int cyc = 0, idle = 0, wcount = 0, ac = 0;
  bit b2b = 1'b0, have_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bval(input int s, input int q, input int w);
    return 8'((s * 50 + q * 7 + w * 3) & 255);
  endfunction

  task automatic push(input int s, input int l, input bit c);
    dlen[s].push_back(l);
    dcor[s].push_back(c);
  endtask

  // source FIFOs and output scoreboard, sampled 1 time unit after each rising edge
  initial forever begin
    @(posedge i_clk);
    #1;
    cyc++;
    for (int s = 0; s < 3; s++) begin
      if (rd_prev[s]) begin
        t_dat[s] = {cur_cor[s] ? (wp[s] == 1 || wp[s] == 30) : (wp[s] == 1 || wp[s] == cur_len[s]),
                    bval(s, seq[s], wp[s])};
        wp[s]++;
      end
      rd_prev[s] = t_rd[s];
      if (t_rd[s]) rd_tot[s]++;
      if (t_ack[s]) begin
        if (dlen[s].size() == 0) chk("ack_empty", 1, 0);
        else begin
          cur_len[s] = dlen[s].pop_front();
          cur_cor[s] = dcor[s].pop_front();
          wp[s] = 1;
          seq[s]++;
          len_tot[s] += cur_len[s];
          gnt_log.push_back(s);
          chk("rd_start", t_rd[s], cur_len[s] != 0);
          if (cur_len[s] != 0)
            chk("len_err", bus.o_len_err, cur_len[s] < 60 || cur_len[s] > 1518);
          if (cur_len[s] >= 60 && cur_len[s] <= 1518) begin
            ackcyc.push_back(cyc);
            for (int w = 1; w <= cur_len[s]; w++)
              expq.push_back({w == 1, cur_cor[s], w == cur_len[s], 2'(s), w == 1 || w == cur_len[s],
                              bval(s, seq[s], w)});
          end
        end
      end
      t_rdy[s] = dlen[s].size() != 0;
      t_len[s] = t_rdy[s] ? 11'(dlen[s][0]) : 11'd0;
    end
    if (bus.o_len_err && t_ack == 3'b000) chk("len_err_stray", 1, 0);
    if (bus.o_fmt_err && !bus.o_data_wr) chk("fmt_err_stray", 1, 0);
    if (bus.o_data_wr) begin
      if (expq.size() == 0) chk("extra_wr", 1, 0);
      else begin
        e = expq.pop_front();
        chk("data", bus.ov_data, e[8:0]);
        if (e[13]) begin
          wcount = 1;
          if (ackcyc.size() != 0) begin
            ac = ackcyc.pop_front();
            chk("latency", cyc - ac, 2);
          end
          if (b2b && have_prev) chk("gap", idle, 20);
        end else begin
          wcount++;
          chk("contig", idle, 0);
        end
        chk("fmt_err", bus.o_fmt_err, e[11] && e[12]);
        if (e[11]) begin
          have_prev = 1'b1;
          cnt_exp[e[10:9]]++;
          chk("cnt", t_cnt[e[10:9]], cnt_exp[e[10:9]]);
        end
      end
      idle = 0;
    end else idle++;
  end

  task automatic drain();
    int n = 0;
    while ((dlen[0].size() + dlen[1].size() + dlen[2].size() + expq.size() != 0 || t_rd != 3'b000)
           && n < 6000) begin
      @(negedge i_clk);
      n++;
    end
    chk("timeout", n >= 6000, 0);
    repeat (30) @(negedge i_clk);
    for (int s = 0; s < 3; s++) begin
      chk("rd_total", rd_tot[s], len_tot[s]);
      chk("cnt_final", t_cnt[s], cnt_exp[s]);
    end
  endtask

  task automatic chk_order();
    chk("order_len", gnt_log.size(), eo.size());
    for (int i = 0; i < eo.size() && i < gnt_log.size(); i++) chk("order", gnt_log[i], eo[i]);
    gnt_log.delete();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #2;
    chk("rst_data", bus.ov_data, 0);
    chk("rst_wr", bus.o_data_wr, 0);
    chk("rst_err", {bus.o_fmt_err, bus.o_len_err}, 0);
    chk("rst_ack", t_ack, 0);
    chk("rst_rd", t_rd, 0);
    for (int s = 0; s < 3; s++) begin
      chk("rst_cnt", t_cnt[s], 0);
      dlen[s].delete();
      dcor[s].delete();
      rd_prev[s] = 1'b0;
      rd_tot[s] = 0;
      len_tot[s] = 0;
      cnt_exp[s] = 0;
      t_rdy[s] = 1'b0;
      t_len[s] = 11'd0;
    end
    expq.delete();
    ackcyc.delete();
    gnt_log.delete();
    have_prev = 1'b0;
    wcount = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    push(SRC_PTP, 64, 1'b0);
    drain();
    eo = '{SRC_PTP};
    chk_order();
    chk("ptp_cnt", t_cnt[SRC_PTP], 1);
    b2b = 1'b1;
    have_prev = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(SRC_NMAC, 60, 1'b0);
      push(SRC_ARP, 60, 1'b0);
    end
    drain();
    eo = '{SRC_NMAC, SRC_ARP, SRC_NMAC, SRC_ARP, SRC_NMAC, SRC_ARP};
    chk_order();
    have_prev = 1'b0;
    push(SRC_NMAC, 60, 1'b0);
    push(SRC_ARP, 60, 1'b0);
    repeat (30) @(negedge i_clk);
    push(SRC_PTP, 60, 1'b0);
    drain();
    eo = '{SRC_NMAC, SRC_PTP, SRC_ARP};
    chk_order();
    b2b = 1'b0;
    push(SRC_PTP, 64, 1'b1);
    drain();
    eo = '{SRC_PTP};
    chk_order();
    push(SRC_PTP, 0, 1'b0);
    push(SRC_NMAC, 40, 1'b0);
    push(SRC_ARP, 2000, 1'b0);
    drain();
    eo = '{SRC_PTP, SRC_NMAC, SRC_ARP};
    chk_order();
    wcount = 0;
    push(SRC_NMAC, 64, 1'b0);
    begin
      int n = 0;
      while (wcount < 30 && n < 500) begin
        @(negedge i_clk);
        n++;
      end
      chk("mid_frame", wcount >= 30, 1);
    end
    do_reset();
    push(SRC_NMAC, 60, 1'b0);
    push(SRC_ARP, 60, 1'b0);
    drain();
    eo = '{SRC_NMAC, SRC_ARP};
    chk_order();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
